pipelined_bypass_adder: RTL and testbench

PIPELINED_BYPASS_ADDER -- requirements
Module: pipelined_bypass_adder

---
 rtl/pba_pkg.sv | 14 +
 rtl/pba_block.sv | 32 +++
 rtl/pipelined_bypass_adder.sv | 170 +++++++++++++++++
 tb/tb_pipelined_bypass_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pba_pkg.sv
// Shared defaults and op-mode type for the pipelined carry-bypass adder.
// Imported by pba_block and pipelined_bypass_adder.
package pba_pkg;

    localparam int PBA_WIDTH  = 32;
    localparam int PBA_BLK    = 4;
    localparam int PBA_STAGES = 2;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pba_block.sv
// One BLK-bit ripple adder slice with carry-bypass select.
// Ports: i_a/i_b operands, i_ci carry-in, o_s sum slice, o_co carry-out.
module pba_block
    import pba_pkg::*;
#(
    parameter int BLK = PBA_BLK
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    input  logic           i_ci,
    output logic [BLK-1:0] o_s,
    output logic           o_co
);

    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_c;

    always_comb begin
        w_p    = i_a ^ i_b;
        w_c    = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < BLK; i++) begin
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_p[i] & w_c[i]);
        end
    end

    assign o_s = w_p ^ w_c[BLK-1:0];

    // All-propagate block: the carry-in skips the ripple chain.
    assign o_co = (&w_p) ? i_ci : w_c[BLK];

endmodule

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor with valid/ready flow control.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub, out_valid/out_ready,
// sum, cout, overflow. Optional PBA_SATURATE_EN clamps sum on overflow.
module pipelined_bypass_adder
    import pba_pkg::*;
#(
    parameter int WIDTH  = PBA_WIDTH,
    parameter int BLK    = PBA_BLK,
    parameter int STAGES = PBA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NB  = WIDTH / BLK;
    localparam int BPS = (NB + STAGES - 1) / STAGES;
    localparam int L   = STAGES - 1;

    if (WIDTH % BLK != 0) begin : g_chk_blk
        $error("WIDTH must be a multiple of BLK");
    end
    if (STAGES < 1 || STAGES > NB) begin : g_chk_stg
        $error("STAGES must be in 1..WIDTH/BLK");
    end

    function automatic logic [WIDTH-1:0] mk_mask(input int lo, input int n);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i < lo + n) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic             r_vld [STAGES];
    op_e              r_op  [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];

    logic             w_v_in  [STAGES];
    op_e              w_op_in [STAGES];
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_bx    [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic             w_c_in  [STAGES];
    logic [WIDTH-1:0] w_s_nx  [STAGES];
    logic             w_c_nx  [STAGES];
    logic [STAGES-1:0] w_adv;

    logic [WIDTH-1:0] w_bsum;
    logic [NB-1:0]    w_bci;
    logic [NB-1:0]    w_bco;

    // A stage moves when it is empty or everything downstream can move.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int m = k; m < STAGES; m++) begin
                if (!r_vld[m]) w_adv[k] = 1'b1;
            end
        end
    end

    assign in_ready = w_adv[0];

    for (genvar j = 0; j < NB; j++) begin : g_blk
        localparam int ST = j / BPS;
        if (j % BPS == 0) begin : g_first
            assign w_bci[j] = w_c_in[ST];
        end else begin : g_chain
            assign w_bci[j] = w_bco[j-1];
        end
        pba_block #(.BLK(BLK)) u_blk (
            .i_a  (w_a_in[ST][j*BLK +: BLK]),
            .i_b  (w_bx[ST][j*BLK +: BLK]),
            .i_ci (w_bci[j]),
            .o_s  (w_bsum[j*BLK +: BLK]),
            .o_co (w_bco[j])
        );
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * BPS;
        localparam int HI = ((s + 1) * BPS < NB) ? (s + 1) * BPS : NB;

        if (s == 0) begin : g_in
            assign w_v_in[s]  = in_valid;
            assign w_op_in[s] = sub ? OP_SUB : OP_ADD;
            assign w_a_in[s]  = a;
            assign w_b_in[s]  = b;
            assign w_s_in[s]  = '0;
            // Subtraction injects the +1 of two's complement.
            assign w_c_in[s]  = sub ? 1'b1 : cin;
        end else begin : g_fwd
            assign w_v_in[s]  = r_vld[s-1];
            assign w_op_in[s] = r_op[s-1];
            assign w_a_in[s]  = r_a[s-1];
            assign w_b_in[s]  = r_b[s-1];
            assign w_s_in[s]  = r_s[s-1];
            assign w_c_in[s]  = r_c[s-1];
        end

        assign w_bx[s] = (w_op_in[s] == OP_SUB) ? ~w_b_in[s] : w_b_in[s];

        if (HI > LO) begin : g_work
            localparam logic [WIDTH-1:0] MASK =
                mk_mask(LO * BLK, (HI - LO) * BLK);
            assign w_s_nx[s] = (w_s_in[s] & ~MASK) | (w_bsum & MASK);
            assign w_c_nx[s] = w_bco[HI-1];
        end else begin : g_pass
            assign w_s_nx[s] = w_s_in[s];
            assign w_c_nx[s] = w_c_in[s];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld[s] <= 1'b0;
                r_op[s]  <= OP_ADD;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_s[s]   <= '0;
                r_c[s]   <= 1'b0;
            end else if (w_adv[s]) begin
                r_vld[s] <= w_v_in[s];
                r_op[s]  <= w_op_in[s];
                r_a[s]   <= w_a_in[s];
                r_b[s]   <= w_b_in[s];
                r_s[s]   <= w_s_nx[s];
                r_c[s]   <= w_c_nx[s];
            end
        end
    end

    logic w_bmsb;
    logic w_amsb;
    logic w_ovf;

    assign w_amsb = r_a[L][WIDTH-1];
    assign w_bmsb = (r_op[L] == OP_SUB) ? ~r_b[L][WIDTH-1] : r_b[L][WIDTH-1];
    assign w_ovf  = (w_amsb == w_bmsb) && (r_s[L][WIDTH-1] != w_amsb);

    assign out_valid = r_vld[L];
    assign cout      = r_c[L];
    assign overflow  = w_ovf;

`ifdef PBA_SATURATE_EN
    // Operand sign tells which rail was crossed.
    assign sum = !w_ovf ? r_s[L] :
                 w_amsb ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum = r_s[L];
`endif

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Self-checking bench for pipelined_bypass_adder: directed vector table,
// stall/stream and reset sequences, plus 16-bit STAGES=1..4 random sweep.
module tb_pipelined_bypass_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipelined_bypass_adder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum} for a w-bit operation.
    function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                          input logic [63:0] y,
                                          input logic ci, input logic s);
        logic [64:0] t;
        logic [63:0] m;
        logic [63:0] xx;
        logic [63:0] yy;
        logic [63:0] sm;
        logic        co;
        logic        ov;
        m  = (64'd1 << w) - 64'd1;
        xx = x & m;
        yy = (s ? ~y : y) & m;
        t  = {1'b0, xx} + {1'b0, yy} + (s ? 65'd1 : {64'd0, ci});
        sm = t[63:0] & m;
        co = t[w];
        ov = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
`ifdef PBA_SATURATE_EN
        if (ov) sm = xx[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 1);
`endif
        return {ov, co, sm};
    endfunction

    // ---------------- 16-bit sweep instances ----------------
    logic        sw_on = 1'b0;
    logic        s_vld = 1'b0;
    logic        s_ordy = 1'b1;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        s_cin = 1'b0;
    logic        s_sub = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        logic        rdy;
        logic        ov;
        logic [15:0] sm;
        logic        co;
        logic        of;
        logic [65:0] q [$];
        logic [65:0] e;

        pipelined_bypass_adder #(.WIDTH(16), .BLK(4), .STAGES(g + 1)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_vld),
            .in_ready  (rdy),
            .a         (s_a),
            .b         (s_b),
            .cin       (s_cin),
            .sub       (s_sub),
            .out_valid (ov),
            .out_ready (s_ordy),
            .sum       (sm),
            .cout      (co),
            .overflow  (of)
        );

        always @(negedge clk) begin
            if (sw_on) begin
                if (ov && s_ordy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sw%0d_extra", g + 1), 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d_res", g + 1),
                            {of, co, sm}, {e[65:64], e[15:0]});
                    end
                end
                if (s_vld && rdy) begin
                    q.push_back(model(16, {48'd0, s_a}, {48'd0, s_b},
                                      s_cin, s_sub));
                end
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic [31:0] s_sat;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt [12];

    task automatic run_vec(input int i);
        int lat;
        logic [31:0] es;
        @(posedge clk); #1;
        a = vt[i].a;
        b = vt[i].b;
        cin = vt[i].cin;
        sub = vt[i].sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
`ifdef PBA_SATURATE_EN
        es = vt[i].s_sat;
`else
        es = vt[i].s;
`endif
        chk($sformatf("v%0d_latency", i), lat, 2);
        chk($sformatf("v%0d_sum", i), sum, es);
        chk($sformatf("v%0d_cout", i), cout, vt[i].co);
        chk($sformatf("v%0d_ovf", i), overflow, vt[i].ov);
    endtask

    task automatic stream_test();
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic        sc [8];
        logic        ss [8];
        logic [65:0] ex [8];
        int ii;
        int oi;
        int cyc;
        logic saw_full;
        ii = 0;
        oi = 0;
        cyc = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = 32'h0101_0101 * i + 32'h7FFF_FFF0;
            sb[i] = 32'h00FF_00FF ^ i;
            sc[i] = i[1];
            ss[i] = i[0];
            ex[i] = model(32, {32'd0, sa[i]}, {32'd0, sb[i]}, sc[i], ss[i]);
        end
        while (oi < 8 && cyc < 60) begin
            @(posedge clk); #1;
            if (ii < 8) begin
                a = sa[ii];
                b = sb[ii];
                cin = sc[ii];
                sub = ss[ii];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (out_valid) begin
                chk($sformatf("st%0d_res", oi),
                    {overflow, cout, sum}, {ex[oi][65:64], ex[oi][31:0]});
                if (out_ready) oi++;
            end
            if (in_valid && in_ready) ii++;
            cyc++;
        end
        chk("stream_count", oi, 8);
        chk("stream_full_seen", saw_full, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic reset_test();
        int stale;
        @(posedge clk); #1;
        a = 32'd1;
        b = 32'd2;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd3;
        b = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        chk("rst_pre_valid", out_valid, 1);
        chk("rst_pre_sum", sum, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sum", sum, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rst_stale", stale, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 0, 0,
                   32'h80000000, 32'h7FFFFFFF, 0, 1};
        vt[1]  = '{32'hFFFFFFFF, 32'h00000000, 1, 0,
                   32'h00000000, 32'h00000000, 1, 0};
        vt[2]  = '{32'h00000005, 32'h00000007, 0, 1,
                   32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0};
        vt[3]  = '{32'h00000007, 32'h00000005, 0, 1,
                   32'h00000002, 32'h00000002, 1, 0};
        vt[4]  = '{32'h12345678, 32'h11111111, 1, 0,
                   32'h2345678A, 32'h2345678A, 0, 0};
        vt[5]  = '{32'h80000000, 32'h80000000, 0, 0,
                   32'h00000000, 32'h80000000, 1, 1};
        vt[6]  = '{32'h80000000, 32'h00000001, 0, 1,
                   32'h7FFFFFFF, 32'h80000000, 1, 1};
        vt[7]  = '{32'h00000000, 32'h00000000, 1, 1,
                   32'h00000000, 32'h00000000, 1, 0};
        vt[8]  = '{32'h00000000, 32'h00000000, 1, 0,
                   32'h00000001, 32'h00000001, 0, 0};
        vt[9]  = '{32'h00000000, 32'h00000001, 0, 1,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
        vt[10] = '{32'h0000FFFF, 32'h00000001, 0, 0,
                   32'h00010000, 32'h00010000, 0, 0};
        vt[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 0, 1,
                   32'h80000000, 32'h7FFFFFFF, 0, 1};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) run_vec(i);

        stream_test();
        reset_test();

        sw_on = 1'b1;
        for (int c = 0; c < 1400; c++) begin
            @(posedge clk); #1;
            s_a = 16'($urandom);
            s_b = 16'($urandom);
            s_cin = 1'($urandom);
            s_sub = 1'($urandom);
            s_vld = ($urandom_range(0, 9) != 0);
            s_ordy = ($urandom_range(0, 4) != 0);
        end
        @(posedge clk); #1;
        s_vld = 1'b0;
        s_ordy = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("sw1_drain", g_sw[0].q.size(), 0);
        chk("sw2_drain", g_sw[1].q.size(), 0);
        chk("sw3_drain", g_sw[2].q.size(), 0);
        chk("sw4_drain", g_sw[3].q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
